// File: rtl/rvsoc_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and the transmit FSM states.
package rvsoc_mmio_pkg;

  localparam logic [2:0] UART_TXDATA_OFS = 3'd0;
  localparam logic [2:0] UART_STATUS_OFS = 3'd4;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } uart_tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_byte_fifo.sv
// Circular byte FIFO with a show-ahead head. A push into a full FIFO is still
// accepted when a pop happens in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][7:0] mem_q;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once count covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// UART transmitter on the data-memory bus: TXDATA pushes a byte into the FIFO,
// STATUS reports {ovf, busy, empty, full}; bytes leave 8N1, LSB first, on tx.
module mmio_uart_tx
  import rvsoc_mmio_pkg::*;
#(
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Addr,
  input  logic [31:0] DataW,
  input  logic        MemRW,
  input  logic [1:0]  LenSel,
  output logic        sel,
  output logic [31:0] DataR,
  output logic        tx
);

  localparam int             BW     = $clog2(CLK_DIV);
  localparam logic [BW-1:0]  DIV_M1 = BW'(CLK_DIV - 1);

  uart_tx_state_t          state_q, state_d;
  logic [BW-1:0]           baud_q, baud_d;
  logic [7:0]              shift_q, shift_d;
  logic [2:0]              idx_q, idx_d;
  logic                    ovf_q, ovf_d;
  logic                    tx_q, tx_d;
  logic                    push_req, clr_ovf, pop;
  logic                    fifo_full, fifo_empty;
  logic [7:0]              fifo_dout;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [3:0]              status;
  logic                    unused_ok;

  assign unused_ok = ^{LenSel, DataW[31:8], DataW[2:0], Addr[1:0], fifo_count};

  assign sel      = (Addr[31:3] == BASE_ADDR[31:3]);
  assign push_req = MemRW & sel & (Addr[2] == UART_TXDATA_OFS[2]);
  assign clr_ovf  = MemRW & sel & (Addr[2] == UART_STATUS_OFS[2]) & DataW[ST_OVF];

  always_comb begin
    status           = '0;
    status[ST_FULL]  = fifo_full;
    status[ST_EMPTY] = fifo_empty;
    status[ST_BUSY]  = (state_q != S_IDLE);
    status[ST_OVF]   = ovf_q;
  end

  assign DataR = (sel && Addr[2] == UART_STATUS_OFS[2]) ? {28'b0, status} : 32'b0;
  assign tx    = tx_q;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .pop   (pop),
    .din   (DataW[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A dropped byte sets ovf even when software clears it in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf)                           ovf_d = 1'b0;
    if (push_req && fifo_full && !pop)     ovf_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          baud_d  = DIV_M1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_q == '0) begin
          baud_d  = DIV_M1;
          idx_d   = '0;
          state_d = S_DATA;
        end else baud_d = baud_q - 1'b1;
      end
      S_DATA: begin
        if (baud_q == '0) begin
          baud_d  = DIV_M1;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else baud_d = baud_q - 1'b1;
      end
      S_STOP: begin
        if (baud_q == '0) begin
          baud_d = DIV_M1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            state_d = S_START;
          end else state_d = S_IDLE;
        end else baud_d = baud_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // tx is registered from the next state so the line changes on the transition edge.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: decode table, serial-frame scoreboard, overflow,
// address misses and reset mid-frame.
module tb_mmio_uart_tx;

  localparam int          CD   = 4;
  localparam int          FD   = 8;
  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk, rst_n, MemRW, sel, tx;
  logic [31:0] Addr, DataW, DataR;
  logic [1:0]  LenSel;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_store_cyc = 0;
  logic [7:0]  expq[$];
  int          starts[$];

  typedef struct {
    logic [31:0] addr;
    logic        exp_sel;
    logic [31:0] exp_datar;
    string       name;
  } vec_t;
  vec_t vecs[7];

  mmio_uart_tx #(.CLK_DIV(CD), .FIFO_DEPTH(FD), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .Addr(Addr), .DataW(DataW), .MemRW(MemRW),
    .LenSel(LenSel), .sel(sel), .DataR(DataR), .tx(tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Serial monitor: samples mid-bit on falling edges and scores each frame.
  initial begin
    bit         active;
    int         n;
    logic [7:0] b;
    active = 0; n = 0; b = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        active = 0;
      end else if (!active) begin
        if (tx === 1'b0) begin
          active = 1; n = 0; b = '0;
          starts.push_back(cyc);
        end
      end else begin
        n++;
        if (n == CD/2) chk("start_bit", {31'b0, tx}, 32'd0);
        for (int k = 0; k < 8; k++)
          if (n == CD*(k+1) + CD/2) b[k] = tx;
        if (n == CD*9 + CD/2) begin
          chk("stop_bit", {31'b0, tx}, 32'd1);
          if (expq.size() == 0) chk("unexpected_frame", {24'b0, b}, 32'hFFFF_FFFF);
          else chk("frame_byte", {24'b0, b}, {24'b0, expq.pop_front()});
        end
        if (n == CD*10 - 1) active = 0;
      end
    end
  end

  task automatic run_table();
    for (int i = 0; i < 7; i++) begin
      Addr = vecs[i].addr;
      #1;
      chk({vecs[i].name, "_sel"}, {31'b0, sel}, {31'b0, vecs[i].exp_sel});
      chk({vecs[i].name, "_datar"}, DataR, vecs[i].exp_datar);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    Addr = a; DataW = d; MemRW = 1'b1;
    @(negedge clk);
    last_store_cyc = cyc;
    MemRW = 1'b0; Addr = BASE + 32'd4;
    #1;
  endtask

  task automatic wait_idle(input int bound);
    int k;
    Addr = BASE + 32'd4;
    for (k = 0; k < bound; k++) begin
      @(negedge clk); #1;
      if (DataR == 32'h2) break;
    end
    chk("wait_idle_status", DataR, 32'h2);
  endtask

  initial begin
    int nb, nstart;
    bit tx_ok;
    vecs[0] = '{BASE + 32'd4, 1'b1, 32'h2, "status"};
    vecs[1] = '{32'h0,        1'b0, 32'h0, "zero"};
    vecs[2] = '{BASE,         1'b1, 32'h0, "txdata"};
    vecs[3] = '{BASE + 32'd5, 1'b1, 32'h2, "status_b1"};
    vecs[4] = '{BASE + 32'd8, 1'b0, 32'h0, "above"};
    vecs[5] = '{BASE - 32'd4, 1'b0, 32'h0, "below"};
    vecs[6] = '{BASE + 32'd7, 1'b1, 32'h2, "status_b3"};

    rst_n = 1'b0; Addr = '0; DataW = '0; MemRW = 1'b0; LenSel = 2'd2;
    repeat (2) @(negedge clk);
    run_table();
    chk("reset_tx", {31'b0, tx}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    run_table();

    // Single byte, latency and busy length
    expq.push_back(8'hA5);
    store(BASE, 32'h0000_12A5);
    chk("status_after_push", DataR, 32'h0);
    nb = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (DataR[2]) nb++;
      else if (nb > 0) break;
    end
    chk("busy_cycles", nb, 40);
    chk("single_frames", starts.size(), 1);
    if (starts.size() >= 1) chk("start_latency", starts[0], last_store_cyc + 1);
    wait_idle(50);

    // Back-to-back contiguous frames
    @(negedge clk);
    Addr = BASE; DataW = 32'h00; MemRW = 1'b1; expq.push_back(8'h00);
    @(negedge clk);
    DataW = 32'hFF; expq.push_back(8'hFF);
    @(negedge clk);
    MemRW = 1'b0;
    wait_idle(200);
    chk("b2b_frames", starts.size(), 3);
    if (starts.size() >= 3) chk("b2b_gap", starts[2] - starts[1], 40);

    // Overflow: one popped, eight buffered, tenth dropped
    for (int i = 0; i < 10; i++) begin
      Addr = BASE; DataW = 32'h30 + i; MemRW = 1'b1;
      if (i < 9) expq.push_back(8'(32'h30 + i));
      @(negedge clk);
    end
    MemRW = 1'b0; Addr = BASE + 32'd4;
    #1;
    chk("ovf_status", DataR, 32'hD);
    store(BASE + 32'd4, 32'h8);
    chk("ovf_clear", DataR, 32'h5);
    wait_idle(1000);

    // Address misses
    nstart = starts.size();
    @(negedge clk);
    Addr = BASE + 32'd8; DataW = 32'h55; MemRW = 1'b1;
    #1; chk("miss_hi_sel", {31'b0, sel}, 32'd0);
    @(negedge clk);
    Addr = BASE - 32'd4;
    #1; chk("miss_lo_sel", {31'b0, sel}, 32'd0);
    @(negedge clk);
    MemRW = 1'b0; Addr = BASE + 32'd4;
    #1; chk("miss_status", DataR, 32'h2);
    tx_ok = 1;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_ok = 0;
    end
    chk("miss_tx_idle", {31'b0, tx_ok}, 32'd1);
    chk("miss_no_frame", starts.size(), nstart);

    // Reset during DATA bit 3 of 0xC3 (bit 3 = 0)
    nstart = starts.size();
    expq.push_back(8'hC3);
    store(BASE, 32'hC3);
    repeat (18) @(negedge clk);
    chk("pre_reset_bit3", {31'b0, tx}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("reset_tx_async", {31'b0, tx}, 32'd1);
    void'(expq.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_status", DataR, 32'h2);
    repeat (60) @(negedge clk);
    chk("post_reset_frames", starts.size(), nstart + 1);
    chk("post_reset_idle", DataR, 32'h2);
    chk("queue_drained", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the core's data-memory bus, beside DMEM. Decodes the same address, write data and write-enable the ALU/register bank drive into DMEM, buffers byte stores in a small FIFO, and serialises them 8N1, LSB first, on `tx`. A combinational status read joins the write-back path through `sel`, so software can poll for space.

## Interface
- `CLK_DIV`, 16: clock cycles per serial bit; must be ≥2.
- `FIFO_DEPTH`, 8: byte FIFO entries; must be a power of two, ≥2.
- `BASE_ADDR`, 32'hFFFF_0000: base of the 8-byte register window; must be 8-byte aligned.
- Ports:
  - `clk`  in  1  core clock, rising-edge.
  - `rst_n`  in  1  reset, asynchronous, active-low.
  - `Addr`  in  32  byte address, the ALU result.
  - `DataW`  in  32  store data; only [7:0] is used.
  - `MemRW`  in  1  1 = store this cycle.
  - `LenSel`  in  2  store width; ignored, every width pushes DataW[7:0].
  - `sel`  out  1  combinational; 1 when Addr[31:3] == BASE_ADDR[31:3].
  - `DataR`  out  32  combinational read data; 0 when `sel`=0.
  - `tx`  out  1  serial line; registered; idle high.

## Operation
- Register map, decoded on Addr[2]; Addr[1:0] are ignored.
- TXDATA at offset 0x0:
  - Store with `sel`=1 pushes DataW[7:0].
  - Reads return 0.
- STATUS at offset 0x4:
  - Read returns {28'b0, ovf, busy, empty, full}.
  - A store with DataW[3]=1 clears `ovf`; all other bits of the store are ignored.
- Push rules:
  - A push is accepted when count < FIFO_DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `ovf` is set; `ovf` is sticky.
  - A clear and a set of `ovf` in the same cycle: the set wins.
- Status bits:
  - `busy` = 1 whenever the FSM is not in IDLE.
  - `empty` is (count == 0); `full` is (count == FIFO_DEPTH).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into an 8-bit shift register, load the baud counter with CLK_DIV-1, and go to START.
  - START: tx=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[0] for CLK_DIV cycles, then shift right and increment the bit index. After bit 7, go to STOP.
  - STOP: tx=1 for CLK_DIV cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter:
  - Width $clog2(CLK_DIV).
  - Counts down; a bit ends on the cycle the counter is 0, and the counter reloads to CLK_DIV-1.
- FIFO:
  - Circular buffer; pointers of width $clog2(FIFO_DEPTH) wrap naturally.
  - Count of width $clog2(FIFO_DEPTH)+1.
  - Push and pop in the same cycle leave count unchanged.

## Timing
- Reset values (asynchronous on `rst_n` low): tx=1, FSM=IDLE, count=0, pointers=0, ovf=0, shift=0, baud counter=0.
  - Resulting outputs: `DataR` status = 32'h2 (empty), `sel` depends on `Addr` only.
- Reset mid-frame: tx goes high immediately and the FIFO contents are discarded. The frame is truncated; no completion is attempted.
- Latency:
  - A store at edge N updates count at N.
  - IDLE pops at edge N+1, and tx falls at N+1.
- Frame length: exactly 10·CLK_DIV cycles. Back-to-back frames are contiguous.
- `DataR` and `sel` have zero latency (combinational from `Addr` and state). A status read in the same cycle as a push shows the pre-edge values.
- `MemRW` is held for exactly one cycle per store; each high cycle with `sel`=1 is one push.

## Structure
- Package `rvsoc_mmio_pkg` holds:
  - Offsets `UART_TXDATA_OFS` = 0 and `UART_STATUS_OFS` = 4.
  - Status bit indices FULL=0, EMPTY=1, BUSY=2, OVF=3.
  - The FSM state enum `uart_tx_state_t`.
- One sub-module, `byte_fifo`: parameter DEPTH; ports push, pop, din[7:0], dout[7:0], full, empty, count.
- The top level contains the decode, `ovf`, the FSM, the baud counter and the shift register.

## Test plan
- Reset: hold `rst_n` low, Addr=BASE+4 → DataR=32'h2, tx=1, sel=1; Addr=0 → sel=0, DataR=0.
- Single byte, CLK_DIV=4: store 0xA5 to BASE+0 → tx low for 4 cycles from the next edge, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles; busy=1 for 40 cycles.
- Back-to-back: store 0x00 then 0xFF on consecutive cycles → two contiguous 40-cycle frames, with no idle cycle between the stop bit and the second start bit.
- Overflow, FIFO_DEPTH=8:
  - 10 consecutive stores → first byte popped, 8 buffered, the 10th dropped; STATUS = 32'h9 (ovf, full; busy=1 → 32'hD).
  - Store 32'h8 to BASE+4 → ovf clears.
- Reset mid-frame: drop `rst_n` during DATA bit 3 → tx=1 asynchronously. After release, STATUS=32'h2 and no further frames appear.
- Address miss: store to BASE+8 and to BASE-4 → count unchanged, sel=0, tx stays 1.
